// File: rtl/bsg_cgol_grid.sv
// Conway-style cellular automaton over a width_p x height_p board with programmable birth/survive masks.
// Loads a board, runs frames_i generations (one per cycle), then presents the result until yumi_i.
module bsg_cgol_grid #(
  parameter int width_p       = 8,
  parameter int height_p      = 8,
  parameter int frame_width_p = 16,
  parameter int wrap_p        = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [width_p*height_p-1:0] data_i,
  input  logic [frame_width_p-1:0]    frames_i,
  input  logic [8:0]                  birth_mask_i,
  input  logic [8:0]                  survive_mask_i,
  input  logic                        v_i,
  output logic                        ready_o,
  output logic [width_p*height_p-1:0] data_o,
  output logic                        v_o,
  input  logic                        yumi_i
);

  localparam int cells_lp = width_p * height_p;

  typedef enum logic [1:0] {
    e_idle,
    e_run,
    e_done
  } state_e;

  state_e                   state_r, state_n;
  logic [cells_lp-1:0]      board_r, board_n;
  logic [frame_width_p-1:0] frames_r;
  logic [8:0]               birth_r, survive_r;
  logic                     load, step;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    ready_o = 1'b0;
    v_o     = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_r)
      e_idle: begin
        ready_o = 1'b1;
        if (v_i) begin
          load    = 1'b1;
          state_n = (frames_i == '0) ? e_done : e_run;
        end
      end
      e_run: begin
        step = 1'b1;
        // Counter of 1 means this cycle applies the last generation.
        if (frames_r == frame_width_p'(1)) state_n = e_done;
      end
      e_done: begin
        v_o = 1'b1;
        if (yumi_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      board_r   <= '0;
      frames_r  <= '0;
      birth_r   <= '0;
      survive_r <= '0;
    end else if (load) begin
      board_r   <= data_i;
      frames_r  <= frames_i;
      birth_r   <= birth_mask_i;
      survive_r <= survive_mask_i;
    end else if (step) begin
      board_r  <= board_n;
      frames_r <= frames_r - frame_width_p'(1);
    end
  end

  assign data_o = board_r;

  for (genvar r = 0; r < height_p; r++) begin : g_row
    for (genvar c = 0; c < width_p; c++) begin : g_col
      logic [7:0] nb;
      logic [3:0] cnt;

      for (genvar k = 0; k < 9; k++) begin : g_nb
        if (k != 4) begin : g_use
          localparam int rr_raw_lp = r + k / 3 - 1;
          localparam int cc_raw_lp = c + k % 3 - 1;
          localparam bit in_grid_lp = (rr_raw_lp >= 0) && (rr_raw_lp < height_p)
                                   && (cc_raw_lp >= 0) && (cc_raw_lp < width_p);
          localparam int rr_lp   = (rr_raw_lp + height_p) % height_p;
          localparam int cc_lp   = (cc_raw_lp + width_p) % width_p;
          localparam int slot_lp = (k < 4) ? k : k - 1;
          if ((wrap_p != 0) || in_grid_lp) begin : g_live
            assign nb[slot_lp] = board_r[rr_lp*width_p + cc_lp];
          end else begin : g_dead
            assign nb[slot_lp] = 1'b0;
          end
        end
      end

      always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + 4'(nb[i]);
      end

      assign board_n[r*width_p + c] = board_r[r*width_p + c] ? survive_r[cnt] : birth_r[cnt];
    end
  end

endmodule

// File: tb/tb_bsg_cgol_grid.sv
// Directed-vector bench for bsg_cgol_grid across several grid sizes and edge modes.
module tb_bsg_cgol_grid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fr = '0;
  logic [8:0]  bm = '0, sm = '0;

  // 5x5 no-wrap
  logic [24:0] di5 = '0, do5;
  logic        v5 = 1'b0, y5 = 1'b0, r5, vo5;
  // 8x8 wrap
  logic [63:0] di8 = '0, do8;
  logic        v8 = 1'b0, y8 = 1'b0, r8, vo8;
  // 4x4 wrap
  logic [15:0] di4w = '0, do4w;
  logic        v4w = 1'b0, y4w = 1'b0, r4w, vo4w;
  // 4x4 no-wrap, 3-bit frame counter
  logic [15:0] di4n = '0, do4n;
  logic        v4n = 1'b0, y4n = 1'b0, r4n, vo4n;

  int total = 0;
  int bad   = 0;
  int lat;

  localparam logic [8:0] conway_b = 9'h008, conway_s = 9'h00C;
  localparam logic [8:0] hl_b     = 9'h048;

  always #5 clk = ~clk;

  bsg_cgol_grid #(.width_p(5), .height_p(5), .frame_width_p(16), .wrap_p(0)) u5 (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(di5), .frames_i(fr),
    .birth_mask_i(bm), .survive_mask_i(sm), .v_i(v5), .ready_o(r5),
    .data_o(do5), .v_o(vo5), .yumi_i(y5));

  bsg_cgol_grid #(.width_p(8), .height_p(8), .frame_width_p(16), .wrap_p(1)) u8 (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(di8), .frames_i(fr),
    .birth_mask_i(bm), .survive_mask_i(sm), .v_i(v8), .ready_o(r8),
    .data_o(do8), .v_o(vo8), .yumi_i(y8));

  bsg_cgol_grid #(.width_p(4), .height_p(4), .frame_width_p(16), .wrap_p(1)) u4w (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(di4w), .frames_i(fr),
    .birth_mask_i(bm), .survive_mask_i(sm), .v_i(v4w), .ready_o(r4w),
    .data_o(do4w), .v_o(vo4w), .yumi_i(y4w));

  bsg_cgol_grid #(.width_p(4), .height_p(4), .frame_width_p(3), .wrap_p(0)) u4n (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(di4n), .frames_i(fr[2:0]),
    .birth_mask_i(bm), .survive_mask_i(sm), .v_i(v4n), .ready_o(r4n),
    .data_o(do4n), .v_o(vo4n), .yumi_i(y4n));

  task automatic test_reset();
    #2;
    total++; if ({r5, vo5, do5} !== {1'b1, 1'b0, 25'h0}) begin bad++; $display("FAIL reset_u5 got r=%b v=%b d=%h want r=1 v=0 d=0", r5, vo5, do5); end
    total++; if ({r8, vo8, do8} !== {1'b1, 1'b0, 64'h0}) begin bad++; $display("FAIL reset_u8 got r=%b v=%b d=%h want r=1 v=0 d=0", r8, vo8, do8); end
    total++; if ({r4w, vo4w, do4w, r4n, vo4n, do4n} !== {1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0}) begin bad++; $display("FAIL reset_u4 got r=%b%b v=%b%b", r4w, r4n, vo4w, vo4n); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if ({r5, vo5} !== 2'b10) begin bad++; $display("FAIL reset_release got r=%b v=%b want r=1 v=0", r5, vo5); end
  endtask

  // Loads u5 at the next negedge; returns number of edges until v_o (load edge counts as 1).
  task automatic run5(input logic [24:0] b, input logic [15:0] f, input logic [8:0] bmask, input logic [8:0] smask, output int l);
    @(negedge clk); di5 = b; fr = f; bm = bmask; sm = smask; v5 = 1'b1;
    @(negedge clk); v5 = 1'b0; l = 1;
    while (vo5 !== 1'b1 && l < 200) begin @(negedge clk); l++; end
  endtask

  task automatic consume5();
    y5 = 1'b1; @(negedge clk); y5 = 1'b0;
  endtask

  task automatic test_blinker();
    logic [24:0] horiz, vert;
    horiz = '0; horiz[11] = 1'b1; horiz[12] = 1'b1; horiz[13] = 1'b1;
    vert  = '0; vert[7]   = 1'b1; vert[12]  = 1'b1; vert[17]  = 1'b1;
    run5(horiz, 16'd1, conway_b, conway_s, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL blinker1_latency got %0d want 2", lat); end
    total++; if (do5 !== vert) begin bad++; $display("FAIL blinker1_board got %h want %h", do5, vert); end
    consume5();
    total++; if ({r5, vo5, do5} !== {1'b1, 1'b0, vert}) begin bad++; $display("FAIL blinker1_release got r=%b v=%b d=%h", r5, vo5, do5); end
    run5(horiz, 16'd2, conway_b, conway_s, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL blinker2_latency got %0d want 3", lat); end
    total++; if (do5 !== horiz) begin bad++; $display("FAIL blinker2_board got %h want %h", do5, horiz); end
    consume5();
  endtask

  task automatic test_glider_wrap();
    logic [63:0] g;
    g = '0; g[1] = 1'b1; g[10] = 1'b1; g[16] = 1'b1; g[17] = 1'b1; g[18] = 1'b1;
    @(negedge clk); di8 = g; fr = 16'd32; bm = conway_b; sm = conway_s; v8 = 1'b1;
    // Scramble every input after load; the captured copies must govern the run.
    @(negedge clk); v8 = 1'b1; di8 = ~g; bm = 9'h000; sm = 9'h000; fr = 16'd1; lat = 1;
    while (vo8 !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    v8 = 1'b0;
    total++; if (lat != 33) begin bad++; $display("FAIL glider_latency got %0d want 33", lat); end
    total++; if (do8 !== g) begin bad++; $display("FAIL glider_board got %h want %h", do8, g); end
    y8 = 1'b1; @(negedge clk); y8 = 1'b0;
  endtask

  task automatic test_edges();
    @(negedge clk); di4w = 16'h9009; di4n = 16'h9009; fr = 16'd1; bm = conway_b; sm = conway_s; v4w = 1'b1; v4n = 1'b1;
    @(negedge clk); v4w = 1'b0; v4n = 1'b0;
    @(negedge clk);
    total++; if ({vo4n, do4n} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL edge_nowrap got v=%b d=%h want v=1 d=0000", vo4n, do4n); end
    total++; if ({vo4w, do4w} !== {1'b1, 16'h9009}) begin bad++; $display("FAIL edge_wrap got v=%b d=%h want v=1 d=9009", vo4w, do4w); end
    y4w = 1'b1; y4n = 1'b1; @(negedge clk); y4w = 1'b0; y4n = 1'b0;
  endtask

  task automatic test_zero_frames_hold();
    logic [63:0] b;
    int unstable;
    b = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk); di8 = b; fr = 16'd0; bm = conway_b; sm = conway_s; v8 = 1'b1;
    @(negedge clk); v8 = 1'b0;
    total++; if ({vo8, r8, do8} !== {1'b1, 1'b0, b}) begin bad++; $display("FAIL zero_frames got v=%b r=%b d=%h want v=1 r=0 d=%h", vo8, r8, do8, b); end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      di8 = ~di8;
      @(negedge clk);
      if ({vo8, do8} !== {1'b1, b}) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL done_hold got %0d unstable cycles want 0", unstable); end
    y8 = 1'b1; @(negedge clk); y8 = 1'b0;
    total++; if ({r8, vo8, do8} !== {1'b1, 1'b0, b}) begin bad++; $display("FAIL yumi_release got r=%b v=%b d=%h", r8, vo8, do8); end
  endtask

  task automatic test_highlife();
    logic [24:0] b;
    b = '0;
    b[0] = 1'b1; b[1] = 1'b1; b[2] = 1'b1; b[5] = 1'b1; b[7] = 1'b1; b[10] = 1'b1;
    b[18] = 1'b1; b[23] = 1'b1; b[24] = 1'b1;
    run5(b, 16'd1, hl_b, conway_s, lat);
    total++; if ({do5[6], do5[19]} !== 2'b11) begin bad++; $display("FAIL highlife_births got six=%b three=%b want 1 1", do5[6], do5[19]); end
    consume5();
    run5(b, 16'd1, conway_b, conway_s, lat);
    total++; if ({do5[6], do5[19]} !== 2'b01) begin bad++; $display("FAIL conway_births got six=%b three=%b want 0 1", do5[6], do5[19]); end
    consume5();
  endtask

  task automatic test_max_frames();
    @(negedge clk); di4n = 16'h0660; fr = 16'd7; bm = conway_b; sm = conway_s; v4n = 1'b1;
    @(negedge clk); v4n = 1'b0; lat = 1;
    while (vo4n !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    total++; if (lat != 8) begin bad++; $display("FAIL max_frames_latency got %0d want 8", lat); end
    total++; if (do4n !== 16'h0660) begin bad++; $display("FAIL max_frames_board got %h want 0660", do4n); end
    y4n = 1'b1; @(negedge clk); y4n = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [24:0] horiz;
    int seen;
    horiz = '0; horiz[11] = 1'b1; horiz[12] = 1'b1; horiz[13] = 1'b1;
    @(negedge clk); di5 = horiz; fr = 16'd10; bm = conway_b; sm = conway_s; v5 = 1'b1;
    @(negedge clk); v5 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({do5, vo5, r5} !== {25'h0, 1'b0, 1'b1}) begin bad++; $display("FAIL midrun_reset got d=%h v=%b r=%b want d=0 v=0 r=1", do5, vo5, r5); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (vo5 !== 1'b0 || r5 !== 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrun_no_result got %0d bad cycles want 0", seen); end
    run5(horiz, 16'd2, conway_b, conway_s, lat);
    total++; if (lat != 3 || do5 !== horiz) begin bad++; $display("FAIL post_reset_run got lat=%0d d=%h want lat=3 d=%h", lat, do5, horiz); end
    consume5();
  endtask

  task automatic test_back_to_back();
    logic [24:0] vert;
    vert = '0; vert[7] = 1'b1; vert[12] = 1'b1; vert[17] = 1'b1;
    run5(vert, 16'd0, conway_b, conway_s, lat);
    total++; if (lat != 1 || do5 !== vert) begin bad++; $display("FAIL b2b_first got lat=%0d d=%h want lat=1 d=%h", lat, do5, vert); end
    consume5();
    run5(vert, 16'd3, conway_b, conway_s, lat);
    total++; if (lat != 4 || do5 !== 25'h0003800) begin bad++; $display("FAIL b2b_second got lat=%0d d=%h want lat=4 d=0003800", lat, do5); end
    consume5();
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_glider_wrap();
    test_edges();
    test_zero_frames_hold();
    test_highlife();
    test_max_frames();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
